// File: rtl/trisc_datapath_if.sv
// -----------------------------------------------------------------------------
// trisc_datapath_if
// Bundles the TRISC datapath's control/program inputs and its status outputs.
//   S          : 12-bit control word from the controller
//   prog_en    : program mode (datapath registers hold, S ignored)
//   prog_we    : program-mode memory write strobe
//   prog_addr  : program-mode write address
//   prog_data  : program-mode write data
//   I3..I0     : opcode nibble (IR[7:4]) back to the controller
//   ac, pc     : accumulator and program counter
//   zero       : zero flag
// master = controller / loader side, slave = datapath side.
// -----------------------------------------------------------------------------
interface trisc_datapath_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic [11:0]   S;
   logic          prog_en;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic          I3;
   logic          I2;
   logic          I1;
   logic          I0;
   logic [DW-1:0] ac;
   logic [AW-1:0] pc;
   logic          zero;

   modport master (
      output S, prog_en, prog_we, prog_addr, prog_data,
      input  I3, I2, I1, I0, ac, pc, zero
   );

   modport slave (
      input  S, prog_en, prog_we, prog_addr, prog_data,
      output I3, I2, I1, I0, ac, pc, zero
   );
endinterface

// File: rtl/trisc_datapath.sv
// -----------------------------------------------------------------------------
// trisc_datapath
// TRISC processor datapath: PC, MAR, memory read-address register, 2^AW x DW
// memory, MDR, IR, AC and zero flag, all driven by the controller's 12-bit
// control word. A program-load port fills memory while the processor is idle.
// Ports:
//   Clock  : system clock, rising edge
//   Resetn : asynchronous active-low reset (memory contents are kept)
//   bus    : trisc_datapath_if.slave (S, prog_*, I3..I0, ac, pc, zero)
// -----------------------------------------------------------------------------
module trisc_datapath #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic              Clock,
   input  logic              Resetn,
   trisc_datapath_if.slave   bus
);
   // Control word bit positions
   localparam int S_PC_CLR = 11;
   localparam int S_MAR_PC = 10;
   localparam int S_MEM_RD = 9;
   localparam int S_MDR_LD = 8;
   localparam int S_IR_LD  = 7;
   localparam int S_PC_INC = 6;
   localparam int S_AC_INC = 5;
   localparam int S_AC_CLR = 4;
   localparam int S_AC_LD  = 3;
   localparam int S_Z_LD   = 2;
   localparam int S_MEM_WR = 1;
   localparam int S_PC_JMP = 0;

   localparam int            DEPTH  = 2 ** AW;
   localparam logic [AW-1:0] PC_ONE = AW'(1);
   localparam logic [DW-1:0] AC_ONE = DW'(1);

   logic [AW-1:0] pc_q,  pc_d;
   logic [AW-1:0] mar_q, mar_d;
   logic [AW-1:0] ra_q,  ra_d;    // memory read-address register
   logic [DW-1:0] mdr_q, mdr_d;
   logic [DW-1:0] ir_q,  ir_d;
   logic [DW-1:0] ac_q,  ac_d;
   logic          zero_q, zero_d;

   logic [DW-1:0] mem_q [DEPTH];

   logic [11:0]   s;
   logic          run;

   // Program mode masks the whole control word, so every register holds and
   // a controller MEM_WR can never race a program write.
   assign run = ~bus.prog_en;
   assign s   = run ? bus.S : 12'h000;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      pc_d   = pc_q;
      mar_d  = mar_q;
      ra_d   = ra_q;
      mdr_d  = mdr_q;
      ir_d   = ir_q;
      ac_d   = ac_q;
      zero_d = zero_q;

      // PC: clear beats jump beats increment
      if (s[S_PC_CLR])
         pc_d = '0;
      else if (s[S_PC_JMP])
         pc_d = ir_q[AW-1:0];
      else if (s[S_PC_INC])
         pc_d = pc_q + PC_ONE;

      // MAR: when fetch asserts IR_LD the operand address must win, so the
      // MDR operand field takes precedence over a simultaneous MAR_PC.
      if (s[S_IR_LD])
         mar_d = mdr_q[AW-1:0];
      else if (s[S_MAR_PC])
         mar_d = pc_q;

      if (s[S_MEM_RD])
         ra_d = mar_q;

      // Registered read port: the pre-edge array contents are sampled, which
      // gives read-old-data when MEM_WR hits the same address this edge.
      if (s[S_MDR_LD])
         mdr_d = mem_q[ra_q];

      if (s[S_IR_LD])
         ir_d = mdr_q;

      // AC: clear beats load beats increment
      if (s[S_AC_CLR])
         ac_d = '0;
      else if (s[S_AC_LD])
         ac_d = mdr_q;
      else if (s[S_AC_INC])
         ac_d = ac_q + AC_ONE;

      // Flag reflects the value AC takes on this same edge
      if (s[S_Z_LD])
         zero_d = (ac_d == '0);
   end

   // --------------------------------------------------------------------------
   // Register file
   // --------------------------------------------------------------------------
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         pc_q   <= '0;
         mar_q  <= '0;
         ra_q   <= '0;
         mdr_q  <= '0;
         ir_q   <= '0;
         ac_q   <= '0;
         zero_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         mar_q  <= mar_d;
         ra_q   <= ra_d;
         mdr_q  <= mdr_d;
         ir_q   <= ir_d;
         ac_q   <= ac_d;
         zero_q <= zero_d;
      end
   end

   // --------------------------------------------------------------------------
   // Memory array: no reset so it maps onto RAM primitives and a loaded
   // program survives a processor reset.
   // --------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (bus.prog_en) begin
         if (bus.prog_we)
            mem_q[bus.prog_addr] <= bus.prog_data;
      end else if (bus.S[S_MEM_WR]) begin
         mem_q[mar_q] <= ac_q;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs (all registered values)
   // --------------------------------------------------------------------------
   assign bus.I3   = ir_q[DW-1];
   assign bus.I2   = ir_q[DW-2];
   assign bus.I1   = ir_q[DW-3];
   assign bus.I0   = ir_q[DW-4];
   assign bus.ac   = ac_q;
   assign bus.pc   = pc_q;
   assign bus.zero = zero_q;

endmodule
